button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable synchronized samples needed to accept a level change (board build overrides to 500000).
REQ-002 The block SHALL take parameter REPEAT_DELAY, default 16, meaning cycles from a press pulse to the first auto-repeat pulse.
REQ-003 The block SHALL take parameter REPEAT_RATE, default 8, meaning cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL take parameter REPEAT_EN, default 1, meaning auto-repeat is enabled; 0 means press pulses only.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single system clock, all logic rising-edge.
REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port btnRaw, input, 4 bits: raw asynchronous buttons, active-high; bit3 up, bit2 down, bit1 left, bit0 right.
REQ-008 The block SHALL have port btnLevel, output, 4 bits: debounced button levels, same bit order.
REQ-009 The block SHALL have port btnPulse, output, 4 bits: one-cycle action pulses, same bit order, feeding the game top-level up/down/left/right buttons.
REQ-010 The block SHALL have port anyPress, output, 1 bit: OR of btnPulse.

Function
REQ-011 Each channel SHALL pass btnRaw through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each channel SHALL keep a 20-bit debounce counter, cleared in any cycle where sync2 equals btnLevel.
REQ-013 The debounce counter SHALL increment in each cycle where sync2 differs from btnLevel.
REQ-014 btnLevel SHALL toggle and the counter SHALL clear on the edge where the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs.
REQ-015 Latency: with btnRaw high before edge 0 and held, btnLevel SHALL be high after edge DEBOUNCE_CYCLES+1 (edge 5 at default).
REQ-016 A raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no btnLevel change and no pulse.
REQ-017 The press pulse SHALL be registered so that btnPulse[i] is high for exactly the one cycle following the edge where btnLevel[i] goes 0->1.
REQ-018 A release (btnLevel 1->0) SHALL produce no pulse.
REQ-019 Each channel SHALL have a 20-bit repeat counter in state IDLE, DELAY or RATE; IDLE is entered on reset or btnLevel=0.
REQ-020 The repeat counter SHALL move IDLE->DELAY at the press pulse, with the counter at 0.
REQ-021 In DELAY, a repeat pulse SHALL fire REPEAT_DELAY cycles after the press pulse, then the counter SHALL enter RATE.
REQ-022 In RATE, a repeat pulse SHALL fire every REPEAT_RATE cycles while the button is held.
REQ-023 Pulse schedule relative to press edge P: P, P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_RATE, and so on.
REQ-024 Multi-press lockout: while more than one btnLevel bit is high, all repeat counters SHALL be held in DELAY with count 0, and only press pulses SHALL be issued.
REQ-025 When the lockout ends with one button still held, that channel SHALL emit its next repeat REPEAT_DELAY cycles later, with no immediate pulse.
REQ-026 Simultaneous press pulses on several channels in the same cycle SHALL all be issued; there is no arbitration.
REQ-027 When REPEAT_EN=0, repeat counters SHALL stay IDLE.
REQ-028 Parameter limits SHALL be DEBOUNCE_CYCLES 1..2^20-1 and REPEAT_DELAY, REPEAT_RATE 2..2^20-1; counters SHALL never wrap inside these limits.

Reset
REQ-029 Asserting RST SHALL immediately clear sync flops, btnLevel, btnPulse, anyPress and all counters to 0, and set repeat state to IDLE, regardless of clock.
REQ-030 A button held through reset release SHALL be treated as a new press: btnLevel rises and a press pulse fires DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Verification (defaults D=4, RD=16, RR=8)
REQ-031 Hold btnRaw[3] high from before edge 0 for 40 cycles -> btnLevel[3] rises after edge 5; btnPulse[3] and anyPress high single cycles after edges 6, 22, 30, 38; other bits stay 0.
REQ-032 Pulse btnRaw[1] high for 3 cycles only -> btnLevel and btnPulse stay 0 throughout.
REQ-033 Settled press on bit0, then btnRaw[0] low before edge R -> btnLevel[0] falls after edge R+5, with no pulse on release.
REQ-034 Hold bits 3 and 2 together -> one press pulse on each in the same cycle and no repeats; drop bit2 -> btnLevel[2] falls, then bit3 repeats 16 cycles later and every 8 cycles after.
REQ-035 Assert RST mid-hold between pulses -> all outputs 0 asynchronously; release with button still held -> press pulse 6 edges after the first post-reset edge.
REQ-036 Set REPEAT_EN=0 and hold bit2 for 60 cycles -> exactly one pulse, after edge 6.

Source files
------------

// File: rtl/button_conditioner.sv
`timescale 1ns / 1ps
`default_nettype none
// ---------------------------------------------------------------------------
// button_conditioner: per-button sync, debounce, press pulse and auto-repeat.
// Revision 1.0
// ---------------------------------------------------------------------------
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_RATE     = 8,
   parameter int REPEAT_EN       = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] btnRaw,
   output logic [3:0] btnLevel,
   output logic [3:0] btnPulse,
   output logic       anyPress
);

   localparam logic [1:0]  S_IDLE     = 2'd0;
   localparam logic [1:0]  S_DELAY    = 2'd1;
   localparam logic [1:0]  S_RATE     = 2'd2;
   localparam logic [19:0] DEB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
   localparam logic [19:0] DELAY_LAST = 20'(REPEAT_DELAY - 1);
   localparam logic [19:0] RATE_LAST  = 20'(REPEAT_RATE - 1);
   localparam bit          RPT_ON     = (REPEAT_EN != 0);

   logic [3:0]  sync1_q, sync2_q;
   logic [3:0]  level_q, level_d, level_prev_q;
   logic [3:0]  pulse_q, pulse_d;
   logic [19:0] deb_cnt_q [4];
   logic [19:0] deb_cnt_d [4];
   logic [1:0]  state_q   [4];
   logic [1:0]  state_d   [4];
   logic [19:0] rep_cnt_q [4];
   logic [19:0] rep_cnt_d [4];
   logic [3:0]  press;
   logic [3:0]  rep_fire;
   logic        multi;

   assign press = level_q & ~level_prev_q;
   assign multi = ($countones(level_q) > 1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         level_q      <= '0;
         level_prev_q <= '0;
         pulse_q      <= '0;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= '0;
            state_q[i]   <= S_IDLE;
            rep_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q      <= btnRaw;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         pulse_q      <= pulse_d;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
            state_q[i]   <= state_d[i];
            rep_cnt_q[i] <= rep_cnt_d[i];
         end
      end
   end

   // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < 4; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (sync2_q[i] == level_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] == DEB_LAST) begin
            level_d[i]   = ~level_q[i];
            deb_cnt_d[i] = '0;
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
         end
      end
   end

   // Repeat schedulers; a press or a multi-button hold restarts the delay phase.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i]   = state_q[i];
         rep_cnt_d[i] = rep_cnt_q[i];
         if (!RPT_ON || !level_q[i]) begin
            state_d[i]   = S_IDLE;
            rep_cnt_d[i] = '0;
         end else if (press[i] || multi) begin
            state_d[i]   = S_DELAY;
            rep_cnt_d[i] = '0;
         end else begin
            case (state_q[i])
               S_DELAY: begin
                  if (rep_cnt_q[i] == DELAY_LAST) begin
                     state_d[i]   = S_RATE;
                     rep_cnt_d[i] = '0;
                  end else begin
                     rep_cnt_d[i] = rep_cnt_q[i] + 20'd1;
                  end
               end
               S_RATE: begin
                  if (rep_cnt_q[i] == RATE_LAST) rep_cnt_d[i] = '0;
                  else                           rep_cnt_d[i] = rep_cnt_q[i] + 20'd1;
               end
               default: begin
                  state_d[i]   = S_IDLE;
                  rep_cnt_d[i] = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < 4; i++) begin
         if (RPT_ON && level_q[i] && !multi && !press[i]) begin
            rep_fire[i] = ((state_q[i] == S_DELAY) && (rep_cnt_q[i] == DELAY_LAST)) ||
                          ((state_q[i] == S_RATE)  && (rep_cnt_q[i] == RATE_LAST));
         end
      end
      pulse_d = press | rep_fire;
   end

   assign btnLevel = level_q;
   assign btnPulse = pulse_q;
   assign anyPress = |pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns / 1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_button_conditioner: randomized and directed checks against a schedule model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 16;
   localparam int RR = 8;

   logic       CLK;
   logic       RST;
   logic [3:0] btnRaw;
   logic [3:0] lvl_a, pls_a, lvl_b, pls_b;
   logic       any_a, any_b;

   int checks = 0;
   int errors = 0;

   // model state
   logic [3:0] m_s1, m_s2, m_lvl, m_lvl_prev, e_pls_a, e_pls_b;
   int         m_run    [4];
   int         m_anchor [4];
   int         m_n;

   button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_EN(1)) dut (
      .CLK(CLK), .RST(RST), .btnRaw(btnRaw), .btnLevel(lvl_a), .btnPulse(pls_a), .anyPress(any_a));

   button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_EN(0)) dut_nr (
      .CLK(CLK), .RST(RST), .btnRaw(btnRaw), .btnLevel(lvl_b), .btnPulse(pls_b), .anyPress(any_b));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0;
      e_pls_a = '0; e_pls_b = '0; m_n = 0;
      for (int i = 0; i < 4; i++) begin
         m_run[i] = 0;
         m_anchor[i] = -1;
      end
   endtask

   // One clock edge of the behavioural model; raw is the value sampled at that edge.
   task automatic model_step(input logic [3:0] raw);
      logic [3:0] l1, press, rep, nl;
      bit         multi;
      int         d;
      l1    = m_lvl;
      press = l1 & ~m_lvl_prev;
      multi = ($countones(l1) > 1);
      rep   = '0;
      for (int i = 0; i < 4; i++) begin
         if (!l1[i]) m_anchor[i] = -1;
         else if (press[i] || multi) m_anchor[i] = m_n;
         else if (m_anchor[i] >= 0) begin
            d = m_n - m_anchor[i];
            if (d >= RD && ((d - RD) % RR) == 0) rep[i] = 1'b1;
         end
      end
      e_pls_a = press | rep;
      e_pls_b = press;
      nl = l1;
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] != l1[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               nl[i] = ~nl[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_lvl_prev = l1;
      m_lvl = nl;
      m_n++;
   endtask

   task automatic tick(input logic [3:0] raw);
      btnRaw = raw;
      @(posedge CLK);
      model_step(raw);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      btnRaw = '0;
      @(negedge CLK);
      @(negedge CLK);
      model_reset();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      btnRaw = 4'hF;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         checks++;
         if ({lvl_a, pls_a, any_a, lvl_b, pls_b, any_b} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got %b/%b/%b %b/%b/%b want all zero",
                     lvl_a, pls_a, any_a, lvl_b, pls_b, any_b);
         end
      end
      model_reset();
      RST = 1'b0;
      for (int e = 0; e < 12; e++) begin
         tick(4'hF);
         checks++;
         if ({lvl_a, pls_a, any_a} !== {m_lvl, e_pls_a, |e_pls_a}) begin
            errors++;
            $display("FAIL reset_all_press edge %0d: got %b/%b/%b want %b/%b/%b",
                     e, lvl_a, pls_a, any_a, m_lvl, e_pls_a, |e_pls_a);
         end
         if (e == 6) begin
            checks++;
            if (pls_a !== 4'hF) begin
               errors++;
               $display("FAIL simultaneous_press: got %b want 1111", pls_a);
            end
         end
      end
   endtask

   task automatic test_hold_up();
      int pe[$];
      int rise;
      rise = -1;
      do_reset();
      for (int e = 0; e < 40; e++) begin
         tick(4'b1000);
         checks++;
         if ({lvl_a, pls_a, any_a} !== {m_lvl, e_pls_a, |e_pls_a}) begin
            errors++;
            $display("FAIL hold_model edge %0d: got %b/%b/%b want %b/%b/%b",
                     e, lvl_a, pls_a, any_a, m_lvl, e_pls_a, |e_pls_a);
         end
         checks++;
         if (lvl_a[2:0] !== 3'b000 || pls_a[2:0] !== 3'b000) begin
            errors++;
            $display("FAIL hold_other_bits edge %0d: got lvl=%b pls=%b want low bits 000", e, lvl_a, pls_a);
         end
         if (pls_a[3]) pe.push_back(e);
         if (lvl_a[3] && rise < 0) rise = e;
      end
      checks++;
      if (rise != 5) begin
         errors++;
         $display("FAIL hold_level_rise: got edge %0d want 5", rise);
      end
      checks++;
      if (pe.size() != 4 || pe[0] != 6 || pe[1] != 22 || pe[2] != 30 || pe[3] != 38) begin
         errors++;
         $display("FAIL hold_pulse_edges: got %p want 6 22 30 38", pe);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int e = 0; e < 20; e++) begin
         tick((e < 3) ? 4'b0010 : 4'b0000);
         checks++;
         if ({lvl_a, pls_a, any_a} !== 9'd0 || {m_lvl, e_pls_a} !== 8'd0) begin
            errors++;
            $display("FAIL glitch edge %0d: got %b/%b/%b model %b/%b want zero",
                     e, lvl_a, pls_a, any_a, m_lvl, e_pls_a);
         end
      end
   endtask

   task automatic test_release();
      int fall;
      fall = -1;
      do_reset();
      for (int e = 0; e < 46; e++) begin
         tick((e < 26) ? 4'b0001 : 4'b0000);
         checks++;
         if ({lvl_a, pls_a, any_a} !== {m_lvl, e_pls_a, |e_pls_a}) begin
            errors++;
            $display("FAIL release_model edge %0d: got %b/%b/%b want %b/%b/%b",
                     e, lvl_a, pls_a, any_a, m_lvl, e_pls_a, |e_pls_a);
         end
         if (e >= 26 && !lvl_a[0] && fall < 0) fall = e;
         if (e >= 32 && e <= 38) begin
            checks++;
            if (pls_a !== 4'b0000) begin
               errors++;
               $display("FAIL release_no_pulse edge %0d: got %b want 0000", e, pls_a);
            end
         end
      end
      checks++;
      if (fall != 31) begin
         errors++;
         $display("FAIL release_fall_edge: got %0d want 31", fall);
      end
   endtask

   task automatic test_multi();
      int pe3[$];
      int pe2[$];
      do_reset();
      for (int e = 0; e < 71; e++) begin
         tick((e < 30) ? 4'b1100 : 4'b1000);
         checks++;
         if ({lvl_a, pls_a, any_a} !== {m_lvl, e_pls_a, |e_pls_a}) begin
            errors++;
            $display("FAIL multi_model edge %0d: got %b/%b/%b want %b/%b/%b",
                     e, lvl_a, pls_a, any_a, m_lvl, e_pls_a, |e_pls_a);
         end
         if (pls_a[3]) pe3.push_back(e);
         if (pls_a[2]) pe2.push_back(e);
      end
      checks++;
      if (pe3.size() != 4 || pe3[0] != 6 || pe3[1] != 51 || pe3[2] != 59 || pe3[3] != 67) begin
         errors++;
         $display("FAIL multi_bit3_edges: got %p want 6 51 59 67", pe3);
      end
      checks++;
      if (pe2.size() != 1 || pe2[0] != 6) begin
         errors++;
         $display("FAIL multi_bit2_edges: got %p want 6", pe2);
      end
   endtask

   task automatic test_reset_midhold();
      int first;
      first = -1;
      do_reset();
      for (int e = 0; e < 26; e++) tick(4'b0010);
      #2 RST = 1'b1;
      #1;
      checks++;
      if ({lvl_a, pls_a, any_a, lvl_b, pls_b, any_b} !== 18'd0) begin
         errors++;
         $display("FAIL async_reset: got %b/%b/%b %b/%b/%b want all zero",
                  lvl_a, pls_a, any_a, lvl_b, pls_b, any_b);
      end
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick(4'b0010);
         checks++;
         if ({lvl_a, pls_a, any_a} !== {m_lvl, e_pls_a, |e_pls_a}) begin
            errors++;
            $display("FAIL midhold_model edge %0d: got %b/%b/%b want %b/%b/%b",
                     e, lvl_a, pls_a, any_a, m_lvl, e_pls_a, |e_pls_a);
         end
         if (pls_a[1] && first < 0) first = e;
      end
      checks++;
      if (first != 6) begin
         errors++;
         $display("FAIL midhold_first_pulse: got edge %0d want 6", first);
      end
   endtask

   task automatic test_no_repeat();
      int cnt, at;
      cnt = 0;
      at = -1;
      do_reset();
      for (int e = 0; e < 60; e++) begin
         tick(4'b0100);
         checks++;
         if ({lvl_b, pls_b, any_b} !== {m_lvl, e_pls_b, |e_pls_b}) begin
            errors++;
            $display("FAIL norepeat_model edge %0d: got %b/%b/%b want %b/%b/%b",
                     e, lvl_b, pls_b, any_b, m_lvl, e_pls_b, |e_pls_b);
         end
         if (any_b) begin
            cnt++;
            at = e;
         end
      end
      checks++;
      if (cnt != 1 || at != 6) begin
         errors++;
         $display("FAIL norepeat_count: got %0d pulses last at %0d want 1 at 6", cnt, at);
      end
   endtask

   task automatic test_random();
      logic [3:0] raw;
      raw = '0;
      do_reset();
      for (int e = 0; e < 900; e++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 23) == 0) raw[b] = ~raw[b];
         tick(raw);
         checks++;
         if ({lvl_a, pls_a, any_a} !== {m_lvl, e_pls_a, |e_pls_a}) begin
            errors++;
            $display("FAIL random_rep edge %0d: got %b/%b/%b want %b/%b/%b",
                     e, lvl_a, pls_a, any_a, m_lvl, e_pls_a, |e_pls_a);
         end
         checks++;
         if ({lvl_b, pls_b, any_b} !== {m_lvl, e_pls_b, |e_pls_b}) begin
            errors++;
            $display("FAIL random_norep edge %0d: got %b/%b/%b want %b/%b/%b",
                     e, lvl_b, pls_b, any_b, m_lvl, e_pls_b, |e_pls_b);
         end
      end
   endtask

   initial begin
      RST = 1'b1;
      btnRaw = '0;
      model_reset();
      test_reset();
      test_hold_up();
      test_glitch();
      test_release();
      test_multi();
      test_reset_midhold();
      test_no_repeat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
